mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit for the MIPS core's execute stage. It sits beside the ALU and takes the same rs/rt operands. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers that MFHI/MFLO read. The datapath uses the `busy` output to stall the PC while an operation is in flight.

## Interface
- Parameters: none. The width is fixed at 32 bits, with a 64-bit HI:LO product.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a mul/div. Accepted only when `busy`=0.
- `op`  in  2  operation: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU. Sampled with `start`.
- `A`  in  32  rs operand: multiplicand/dividend; also the MTHI/MTLO data.
- `B`  in  32  rt operand: multiplier/divisor.
- `we_hi`  in  1  MTHI: write `A` into HI.
- `we_lo`  in  1  MTLO: write `A` into LO.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse: HI/LO updated by the completed operation.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- State machine states:
  - IDLE: `busy`=0.
  - CALC: 32 iterations, 5-bit counter `cnt` counting 0..31.
  - FIX: sign correction and HI/LO write.
- Transitions:
  - IDLE -> CALC on `start`. The edge latches `op`, the operand magnitudes and the sign flags, and clears the accumulator and `cnt`.
  - CALC -> FIX on the edge where `cnt`==31.
  - FIX -> IDLE unconditionally.
- Signed ops (MULT, DIV):
  - Magnitudes are taken as two's-complement absolute values, modulo 2^32, so abs(0x80000000) = 0x80000000 as unsigned.
  - sA = A[31], sB = B[31].
- Unsigned ops: sA = sB = 0.
- Multiply:
  - Radix-2 shift-add over a 64-bit accumulator, one multiplier bit per CALC cycle.
  - FIX negates the 64-bit product when sA^sB, then writes HI = P[63:32] and LO = P[31:0].
- Divide:
  - Restoring division, one quotient bit per CALC cycle, using a 33-bit partial remainder.
  - FIX writes LO = quotient, negated if sA^sB, and HI = remainder, negated if sA.
  - The quotient truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives LO = 0x80000000 and HI = 0.
- Divide by zero (B==0):
  - The full latency is still taken.
  - FIX writes LO = 0xFFFFFFFF and HI = the original `A`, for both signed and unsigned ops.
- MTHI/MTLO:
  - In IDLE with `start`=0, `we_hi`/`we_lo` write `A` into HI/LO on the edge. Both may be asserted together.
  - While `busy`=1, or on the same edge a `start` is accepted, they are dropped. `start` has priority.
- `start` while `busy`=1 is ignored. No queueing.
- `hi` and `lo` change only on a FIX edge, an accepted MTHI/MTLO edge, or reset.

## Timing
- Reset, asynchronous and at any time, including mid-operation:
  - State returns to IDLE and the operation is aborted with no partial write.
  - `hi` = `lo` = 0, `busy` = 0, `done` = 0, `cnt` = 0.
- Let E0 be the edge that accepts `start`.
  - `busy` is 1 from just after E0 until just after E33 (33 cycles).
  - CALC iterations occur on edges E1..E32.
  - HI/LO are written on edge E33.
  - `done` is 1 for the single cycle following E33, concurrent with `busy`=0.
- A new `start` may be accepted on E34, i.e. in the same cycle `done` is high.
- `hi` and `lo` are registered outputs with no combinational path from any input. An MFHI issued in the `done` cycle reads the new value.
- `busy` is a registered output. The stall controller must hold `start`, `A` and `B` stable only on E0.

## Test plan
- MULT with A=0xFFFFFFFD (-3) and B=5 -> after 33 busy cycles, `done` pulses; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- MULTU with A=B=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. The same operands under MULT -> `hi`=0, `lo`=1.
- DIV with A=0xFFFFFFF9 (-7) and B=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU with A=100 and B=0 -> `lo`=0xFFFFFFFF, `hi`=0x00000064, with the latency unchanged.
- MTHI with A=0x12345678 in IDLE -> `hi`=0x12345678 on the next edge. Then a MULTU 2*3 with `start` held high plus a mid-op MTLO -> the second start and the MTLO are ignored; the final `hi`=0, `lo`=6; `done` pulses exactly once.
- Start DIVU 1000/7, assert `rst` for 1 cycle at cycle 10 -> `busy`, `hi`, `lo` are 0 immediately, and `done` never pulses. Restart after reset -> `lo`=142, `hi`=6.

Source files
------------

// File: rtl/mdu.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, 32 iterations plus one sign-fix cycle.
module mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        we_hi,
  input  logic        we_lo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        accept;
  logic        is_div, sa, sb;
  logic [31:0] a_mag, b_mag, quo, rem;
  logic [63:0] prod;
  logic [63:0] pp;
  logic [32:0] trial;
  logic        q_bit;
  logic [31:0] rem_nxt;
  logic [31:0] a_orig;
  logic [63:0] prod_fix;
  logic [31:0] res_hi, res_lo;

  function automatic logic [31:0] neg32(input logic [31:0] x, input logic neg);
    logic signed [31:0] s;
    s = $signed(x);
    return neg ? $unsigned(-s) : x;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x, input logic neg);
    logic signed [63:0] s;
    s = $signed(x);
    return neg ? $unsigned(-s) : x;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = CALC;
        accept    = 1'b1;
      end
      CALC: if (cnt == 5'd31) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-iteration datapath terms: partial product and restoring-divide trial subtract
  always_comb begin
    pp      = b_mag[cnt] ? ({32'd0, a_mag} << cnt) : 64'd0;
    trial   = {rem, quo[31]};
    q_bit   = (trial >= {1'b0, b_mag});
    rem_nxt = q_bit ? (trial[31:0] - b_mag) : trial[31:0];
  end

  // Sign correction; A is recovered from its magnitude for the divide-by-zero HI value
  always_comb begin
    a_orig   = neg32(a_mag, sa);
    prod_fix = neg64(prod, sa ^ sb);
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
    if (is_div) begin
      if (b_mag == 32'd0) begin
        res_hi = a_orig;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = neg32(rem, sa);
        res_lo = neg32(quo, sa ^ sb);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 5'd0;
      busy <= 1'b0;
      done <= 1'b0;
      hi   <= 32'd0;
      lo   <= 32'd0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state == FIX);
      if (accept)              cnt <= 5'd0;
      else if (state == CALC)  cnt <= cnt + 5'd1;
      if (state == FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE && !start) begin
        if (we_hi) hi <= A;
        if (we_lo) lo <= A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      is_div <= op[1];
      sa     <= ~op[0] & A[31];
      sb     <= ~op[0] & B[31];
      a_mag  <= neg32(A, ~op[0] & A[31]);
      b_mag  <= neg32(B, ~op[0] & B[31]);
      quo    <= neg32(A, ~op[0] & A[31]);
      rem    <= 32'd0;
      prod   <= 64'd0;
    end else if (state == CALC) begin
      if (!is_div) begin
        prod <= prod + pp;
      end else begin
        rem <= rem_nxt;
        quo <= {quo[30:0], q_bit};
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: a reference model predicts HI/LO and the done cycle,
// and an independent monitor pops and compares on every done pulse.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        we_hi = 1'b0;
  logic        we_lo = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  mdu dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .we_hi(we_hi), .we_lo(we_lo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          dcyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    logic [63:0] p;
    longint      q, r;
    if (!o[1]) begin
      if (!o[0]) p = longint'(int'(a)) * longint'(int'(b));
      else       p = {32'd0, a} * {32'd0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      h = a;
      l = 32'hFFFF_FFFF;
    end else if (!o[0]) begin
      q = longint'(int'(a)) / longint'(int'(b));
      r = longint'(int'(a)) % longint'(int'(b));
      h = r[31:0];
      l = q[31:0];
    end else begin
      h = a % b;
      l = a / b;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_done: got done=1 at cycle %0d required no pulse", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check32("result_hi", hi, mon_e.hi);
        check32("result_lo", lo, mon_e.lo);
        check32("done_cycle", cyc, mon_e.dcyc);
        check32("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Caller is at a negedge with the DUT idle or in its done cycle
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    start = 1'b1; op = o; A = a; B = b;
    model(o, a, b, e.hi, e.lo);
    e.dcyc = cyc + 34;
    sbq.push_back(e);
    cur_hi = e.hi;
    cur_lo = e.lo;
    @(negedge clk);
    start = 1'b0;
    check32("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d required idle", busy, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got done=0 required a pulse");
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    @(negedge clk);
    issue(o, a, b);
  endtask

  logic [31:0] ra, rb, rv, prev_lo;
  logic [1:0]  ro;

  initial begin
    @(negedge clk);
    @(negedge clk);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_done", {31'd0, done}, 32'd0);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    rst = 1'b0;

    run(2'b00, 32'hFFFF_FFFD, 32'd5);
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(2'b10, 32'hFFFF_FFF9, 32'd2);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b11, 32'd100, 32'd0);
    run(2'b10, 32'hFFFF_FF00, 32'd0);
    run(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_idle();

    // MTHI in idle, then MULTU with start held and MTLO attempts
    @(negedge clk);
    we_hi = 1'b1; A = 32'h1234_5678;
    @(negedge clk);
    we_hi = 1'b0;
    check32("mthi", hi, 32'h1234_5678);
    prev_lo = lo;
    we_lo = 1'b1;
    issue(2'b01, 32'd2, 32'd3);
    we_lo = 1'b0;
    start = 1'b1; A = 32'd7; B = 32'd9;
    check32("mtlo_with_start", lo, prev_lo);
    repeat (4) @(negedge clk);
    we_lo = 1'b1; A = 32'h0000_DEAD;
    @(negedge clk);
    we_lo = 1'b0;
    check32("mtlo_while_busy", lo, prev_lo);
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check32("held_start_hi", hi, 32'd0);
    check32("held_start_lo", lo, 32'd6);

    // Reset mid-operation aborts with no write and no done
    @(negedge clk);
    start = 1'b1; op = 2'b11; A = 32'd1000; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check32("midrst_busy", {31'd0, busy}, 32'd0);
    check32("midrst_hi", hi, 32'd0);
    check32("midrst_lo", lo, 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check32("midrst_lo_held", lo, 32'd0);
    run(2'b11, 32'd1000, 32'd7);

    // Back-to-back: a new start accepted in the done cycle
    wait_done();
    issue(2'b00, 32'hFFFF_FFF0, 32'd3);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 2) == 0) begin
        wait_done();
        issue(ro, ra, rb);
      end else begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rv = $urandom;
        we_hi = 1'($urandom_range(0, 1));
        we_lo = 1'($urandom_range(0, 1));
        A = rv;
        if (we_hi) cur_hi = rv;
        if (we_lo) cur_lo = rv;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0;
        check32("mt_hi", hi, cur_hi);
        check32("mt_lo", lo, cur_lo);
        issue(ro, ra, rb);
      end
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
